// File: rtl/menu_select_n.sv
`default_nettype none
// ============================================================================
// Module   : menu_select_n
// Brief    : Push-button stepped display-menu selector. The raw button is
//            synchronised and debounced; each accepted press rotates a one-hot
//            mode register, and the active channel word (primary or alternate)
//            is registered onto the display path every cycle.
// Options  : MENU_AUTO_SCROLL_EN - when defined, a free-running timer also
//            steps the menu every AUTO_PERIOD cycles.
// Revision : 1.0 - initial release
// ============================================================================
module menu_select_n #(
  parameter int NUM_MODES    = 3,
  parameter int DATA_W       = 32,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int AUTO_PERIOD  = 200000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn_next,
  input  logic [NUM_MODES*DATA_W-1:0] ch_data,
  input  logic [NUM_MODES*DATA_W-1:0] alt_data,
  input  logic [NUM_MODES-1:0]        alt_sel,
  output logic [DATA_W-1:0]           selected,
  output logic [NUM_MODES-1:0]        menu_show,
  output logic                        mode_chg
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0]      C_DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [NUM_MODES-1:0] C_MODE0   = NUM_MODES'(1);

  // Elaboration-time sanity check on the configuration
  if ((NUM_MODES < 2) || (NUM_MODES > 8) || (DEBOUNCE_CYC < 1) ||
      (AUTO_PERIOD < 1) || (DATA_W < 1)) begin : g_bad_param
    $error("menu_select_n: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic                 sync1_q;
  logic                 btn_s_q;
  logic [DB_W-1:0]      db_cnt_q;
  logic [DB_W-1:0]      db_cnt_d;
  logic                 btn_db_q;
  logic                 btn_db_d;
  logic                 btn_db_prev_q;
  logic                 btn_step;
  logic                 auto_step;
  logic                 step_any;
  logic [NUM_MODES-1:0] menu_show_q;
  logic [NUM_MODES-1:0] menu_show_d;
  logic                 mode_chg_q;
  logic                 mode_chg_d;
  logic                 illegal_mode;
  logic [DATA_W-1:0]    mux_word;
  logic [DATA_W-1:0]    selected_q;
  logic [DATA_W-1:0]    selected_d;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser; the raw pin feeds the first flop directly
  // --------------------------------------------------------------------------
  // Bring the asynchronous button into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= btn_next;
      btn_s_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce: the synchronised level must differ from the accepted level for
  // DEBOUNCE_CYC consecutive cycles before it is accepted. Any return to the
  // accepted level restarts the count, so short glitches are swallowed.
  // --------------------------------------------------------------------------
  // Next-state for the debounce counter and accepted level
  always_comb begin
    db_cnt_d = db_cnt_q;
    btn_db_d = btn_db_q;
    if (btn_s_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == C_DB_LAST) begin
      btn_db_d = btn_s_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
    end else begin
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
    end
  end

  // A step is the rising edge of the accepted level only; release is ignored
  assign btn_step = btn_db_q & ~btn_db_prev_q;

  // --------------------------------------------------------------------------
  // Optional auto-scroll timer
  // --------------------------------------------------------------------------
`ifdef MENU_AUTO_SCROLL_EN
  localparam int TM_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [TM_W-1:0] C_TM_LAST = TM_W'(AUTO_PERIOD - 1);

  logic [TM_W-1:0] auto_tmr_q;

  assign auto_step = (auto_tmr_q == C_TM_LAST);

  // Free-running timer, restarted by any step so a press defers the next scroll
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_tmr_q <= '0;
    end else if (step_any) begin
      auto_tmr_q <= '0;
    end else begin
      auto_tmr_q <= auto_tmr_q + TM_W'(1);
    end
  end
`else
  assign auto_step = 1'b0;
`endif

  // Coincident button and timer steps merge into a single advance
  assign step_any = btn_step | auto_step;

  // --------------------------------------------------------------------------
  // Mode register
  // --------------------------------------------------------------------------
  // Zero or more than one bit set means the register was corrupted
  assign illegal_mode = (menu_show_q == '0) ||
                        ((menu_show_q & (menu_show_q - NUM_MODES'(1))) != '0);

  // Recovery has priority over a step; otherwise rotate left on each step
  always_comb begin
    menu_show_d = menu_show_q;
    mode_chg_d  = 1'b0;
    if (illegal_mode) begin
      menu_show_d = C_MODE0;
      mode_chg_d  = 1'b1;
    end else if (step_any) begin
      menu_show_d = {menu_show_q[NUM_MODES-2:0], menu_show_q[NUM_MODES-1]};
      mode_chg_d  = 1'b1;
    end
  end

  // Mode state and change-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      menu_show_q <= C_MODE0;
      mode_chg_q  <= 1'b0;
    end else begin
      menu_show_q <= menu_show_d;
      mode_chg_q  <= mode_chg_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output mux: one-hot AND-OR select of primary/alternate word per channel
  // --------------------------------------------------------------------------
  // Combine the active channel's word; non-active channels contribute zero
  always_comb begin
    mux_word = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (menu_show_q[i]) begin
        mux_word = mux_word | (alt_sel[i] ? alt_data[i*DATA_W +: DATA_W]
                                          : ch_data[i*DATA_W +: DATA_W]);
      end
    end
  end

  // A corrupted mode register falls back to the primary word of channel 0
  assign selected_d = illegal_mode ? ch_data[DATA_W-1:0] : mux_word;

  // Display word register, refreshed every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selected_q <= '0;
    end else begin
      selected_q <= selected_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign selected  = selected_q;
  assign menu_show = menu_show_q;
  assign mode_chg  = mode_chg_q;

endmodule
`default_nettype wire

// File: tb/tb_menu_select_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_select_n
// Brief    : Directed self-checking bench for menu_select_n
//            (NUM_MODES=3, DATA_W=32, DEBOUNCE_CYC=4, AUTO_PERIOD=20).
// Revision : 1.0 - initial release
// ============================================================================
module tb_menu_select_n;

  localparam int NM = 3;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn_next = 1'b0;
  logic [NM*DW-1:0] ch_data;
  logic [NM*DW-1:0] alt_data;
  logic [NM-1:0]    alt_sel;
  logic [DW-1:0]    selected;
  logic [NM-1:0]    menu_show;
  logic             mode_chg;

  int n_checks = 0;
  int n_fail   = 0;

  menu_select_n #(
    .NUM_MODES   (NM),
    .DATA_W      (DW),
    .DEBOUNCE_CYC(4),
    .AUTO_PERIOD (20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_next (btn_next),
    .ch_data  (ch_data),
    .alt_data (alt_data),
    .alt_sel  (alt_sel),
    .selected (selected),
    .menu_show(menu_show),
    .mode_chg (mode_chg)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, counting mode_chg pulses and the cycle of the first one
  task automatic run(input int n, output int pulses, output int first);
    pulses = 0;
    first  = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (mode_chg) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
  endtask

  // Hold the button for 'hold' cycles, then release and let it settle
  task automatic press(input int hold, output int pulses, output int first);
    int p2, f2;
    btn_next = 1'b1;
    run(hold, pulses, first);
    btn_next = 1'b0;
    run(12, p2, f2);
    pulses = pulses + p2;
    if (first == 0 && f2 != 0) first = hold + f2;
  endtask

  initial begin
    int p, f;
    ch_data  = {32'd30, 32'd20, 32'd10};
    alt_data = '0;
    alt_sel  = '0;

    // Reset state
    rst_n = 1'b0;
    tick(); tick(); tick();
    check_val("rst_menu_show", 32'(menu_show), 32'd1);
    check_val("rst_selected", selected, 32'd0);
    check_val("rst_mode_chg", 32'(mode_chg), 32'd0);
    rst_n = 1'b1;
    tick();
    check_val("post_rst_selected", selected, 32'd10);
    check_val("post_rst_menu_show", 32'(menu_show), 32'd1);

`ifndef MENU_AUTO_SCROLL_EN
    // Bounce: high 2, low 1, high 2, low -> ignored
    btn_next = 1'b1; tick(); tick();
    btn_next = 1'b0; tick();
    btn_next = 1'b1; tick(); tick();
    btn_next = 1'b0;
    run(12, p, f);
    check_val("bounce_pulses", 32'(p), 32'd0);
    check_val("bounce_menu_show", 32'(menu_show), 32'd1);

    // Clean press: step lands 7 cycles after the pin rises
    press(10, p, f);
    check_val("press1_pulses", 32'(p), 32'd1);
    check_val("press1_latency", 32'(f), 32'd7);
    check_val("press1_menu_show", 32'(menu_show), 32'b010);
    check_val("press1_selected", selected, 32'd20);

    press(10, p, f);
    check_val("press2_pulses", 32'(p), 32'd1);
    check_val("press2_menu_show", 32'(menu_show), 32'b100);
    check_val("press2_selected", selected, 32'd30);

    // Long hold still steps exactly once, and the mode wraps to 0
    press(40, p, f);
    check_val("wrap_pulses", 32'(p), 32'd1);
    check_val("wrap_menu_show", 32'(menu_show), 32'b001);
    check_val("wrap_selected", selected, 32'd10);

    // Alternate word and live data updates in mode 0
    alt_data = {32'd0, 32'd0, 32'd99};
    alt_sel  = 3'b001;
    tick();
    check_val("alt_on_selected", selected, 32'd99);
    alt_sel = 3'b000;
    tick();
    check_val("alt_off_selected", selected, 32'd10);
    ch_data = {32'd30, 32'd20, 32'd11};
    tick();
    check_val("data_update_selected", selected, 32'd11);
    ch_data = {32'd30, 32'd20, 32'd10};
    // Alternate on a non-active channel has no effect
    alt_sel = 3'b010;
    tick();
    check_val("alt_other_selected", selected, 32'd10);
    alt_sel = 3'b000;

    // Move to mode 1 so the following reset is observable
    press(10, p, f);
    check_val("press4_menu_show", 32'(menu_show), 32'b010);
`endif

    // Reset in the middle of a debounce discards the press
    btn_next = 1'b1;
    tick(); tick(); tick();
    rst_n    = 1'b0;
    btn_next = 1'b0;
    tick(); tick();
    check_val("midrst_menu_show", 32'(menu_show), 32'd1);
    check_val("midrst_selected", selected, 32'd0);
    rst_n = 1'b1;
    run(19, p, f);
    check_val("midrst_pulses", 32'(p), 32'd0);
    check_val("midrst_idle_menu_show", 32'(menu_show), 32'd1);
    tick();
`ifdef MENU_AUTO_SCROLL_EN
    check_val("auto_menu_show", 32'(menu_show), 32'b010);
    check_val("auto_mode_chg", 32'(mode_chg), 32'd1);
`else
    check_val("idle_menu_show", 32'(menu_show), 32'b001);
    check_val("idle_mode_chg", 32'(mode_chg), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
